// File: rtl/histogram_cdf_builder.sv
// histogram_cdf_builder: streams 8-bit pixels from image SRAM M1 into a
// 256-bin histogram, then walks the bins once to write the running CDF into
// SRAM M2 (four 20-bit entries per 128-bit word). It also produces CdfMin and
// the divisor used by the output pipeline.
module histogram_cdf_builder #(
    parameter logic [15:0] IMG_BASE = 16'h0000,
    parameter logic [15:0] CDF_BASE = 16'h0000,
    parameter int          CNT_W    = 20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      NumWords,
    output logic [15:0]      M1_ReadAddress,
    input  logic [127:0]     M1_ReadBus,
    output logic             M2_WriteEnable,
    output logic [15:0]      M2_WriteAddress,
    output logic [127:0]     M2_WriteBus,
    output logic [CNT_W-1:0] CdfMin,
    output logic [CNT_W-1:0] divisor,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        COUNT,
        SCAN,
        FINISH,
        DONE
    } stateT;

    stateT            state;
    stateT            nextState;

    logic [CNT_W-1:0] hist [0:255];
    logic [15:0]      numWordsReg;
    logic [15:0]      wordIdx;
    logic [15:0]      readAddr;
    logic [127:0]     pixShift;
    logic [3:0]       laneCnt;
    logic [7:0]       binIdx;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] cdfMinReg;
    logic [CNT_W-1:0] divisorReg;
    logic             minFound;
    logic [95:0]      packBuf;
    logic [15:0]      lastAddr;
    logic [127:0]     lastBus;

    logic [CNT_W-1:0] accNext;
    logic             lastWord;
    logic             writeNow;
    logic [15:0]      wrAddr;
    logic [127:0]     wrData;

    assign accNext        = acc + hist[binIdx];
    assign lastWord       = ((wordIdx + 16'd1) == numWordsReg);
    assign wrAddr         = CDF_BASE + 16'(binIdx[7:2]);
    assign wrData         = {32'(accNext), packBuf};
    assign M1_ReadAddress = readAddr;
    assign CdfMin         = cdfMinReg;
    assign divisor        = divisorReg;

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and strobe outputs
    always_comb begin
        nextState       = state;
        writeNow        = 1'b0;
        done            = 1'b0;
        M2_WriteEnable  = 1'b0;
        M2_WriteAddress = lastAddr;
        M2_WriteBus     = lastBus;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (NumWords == 16'd0) ? SCAN : FETCH;
                end
            end
            FETCH:  nextState = LATCH;
            LATCH:  nextState = COUNT;
            COUNT: begin
                if (laneCnt == 4'd15) begin
                    nextState = lastWord ? SCAN : FETCH;
                end
            end
            SCAN: begin
                writeNow = (binIdx[1:0] == 2'd3);
                if (binIdx == 8'd255) begin
                    nextState = FINISH;
                end
            end
            FINISH: nextState = DONE;
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
        if (writeNow) begin
            M2_WriteEnable  = 1'b1;
            M2_WriteAddress = wrAddr;
            M2_WriteBus     = wrData;
        end
    end

    // Run control, pixel shifting, CDF accumulation and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            numWordsReg <= '0;
            wordIdx     <= '0;
            readAddr    <= '0;
            pixShift    <= '0;
            laneCnt     <= '0;
            binIdx      <= '0;
            acc         <= '0;
            total       <= '0;
            cdfMinReg   <= '0;
            divisorReg  <= '0;
            minFound    <= 1'b0;
            packBuf     <= '0;
            lastAddr    <= '0;
            lastBus     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        numWordsReg <= NumWords;
                        wordIdx     <= '0;
                        readAddr    <= IMG_BASE;
                        laneCnt     <= '0;
                        binIdx      <= '0;
                        acc         <= '0;
                        total       <= '0;
                        cdfMinReg   <= '0;
                        divisorReg  <= '0;
                        minFound    <= 1'b0;
                    end
                end
                LATCH: begin
                    pixShift <= M1_ReadBus;
                    laneCnt  <= '0;
                end
                COUNT: begin
                    pixShift <= pixShift >> 8;
                    total    <= total + CNT_W'(1);
                    laneCnt  <= laneCnt + 4'd1;
                    if (laneCnt == 4'd15) begin
                        wordIdx  <= wordIdx + 16'd1;
                        readAddr <= readAddr + 16'd1;
                    end
                end
                SCAN: begin
                    acc    <= accNext;
                    binIdx <= binIdx + 8'd1;
                    if (!minFound && (accNext != '0)) begin
                        cdfMinReg <= accNext;
                        minFound  <= 1'b1;
                    end
                    case (binIdx[1:0])
                        2'd0:    packBuf[31:0]  <= 32'(accNext);
                        2'd1:    packBuf[63:32] <= 32'(accNext);
                        2'd2:    packBuf[95:64] <= 32'(accNext);
                        default: begin
                            lastAddr <= wrAddr;
                            lastBus  <= wrData;
                        end
                    endcase
                end
                FINISH: begin
                    divisorReg <= (total == cdfMinReg) ? CNT_W'(1) : (total - cdfMinReg);
                end
                default: ;
            endcase
        end
    end

    // Histogram bins: cleared when a run starts, bumped once per counted pixel
    always_ff @(posedge clock) begin
        if (!reset) begin
            if ((state == IDLE) && start) begin
                for (int unsigned i = 0; i < 256; i++) begin
                    hist[8'(i)] <= '0;
                end
            end else if (state == COUNT) begin
                hist[pixShift[7:0]] <= hist[pixShift[7:0]] + CNT_W'(1);
            end
        end
    end

endmodule
